// File: rtl/mul_pkg.sv
// Shared encodings for the multiply sequencer: operation codes, FSM states, default width.
package mul_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CALC  = 2'b01,
        ST_FINAL = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    function automatic logic rs1_signed(input op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic rs2_signed(input op_e op);
        return op == OP_MULH;
    endfunction

endpackage

// File: rtl/pseudoadder.sv
// 3:2 carry-save compressor; carry output is unshifted (bit i weighs 2^(i+1)).
module pseudoadder #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/mul_sequencer.sv
// Iterative radix-4 carry-save multiplier with RISC-V MUL/MULH/MULHSU/MULHU/MULW semantics.
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// CALC  | retiring two multiplier bits per cycle into sum/carry
// FINAL | single carry-propagate add, result half selected and registered
// DONE  | out_valid=1, holding result until out_ready
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);
    localparam int PW = 2 * XLEN;
    localparam int CW = $clog2(XLEN / 2);
    localparam logic [CW-1:0]   CNT_LOAD   = CW'(XLEN / 2 - 1);
    localparam logic [XLEN-1:0] WORD_MASK  = XLEN'(64'h0000_0000_FFFF_FFFF);
    localparam logic [PW-1:0]   HIGH_MASK  = {PW{1'b1}} << (XLEN - 1);
    localparam logic [PW-1:0]   MSB_INJECT = PW'(1) << (XLEN - 1);

    state_e          state;
    op_e             op_q;
    logic            word_q;
    logic            sgn2_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   sum_q, carry_q, mcand_q;
    logic [XLEN-1:0] mplier_q;

    op_e             op_in;
    logic            word_in, zero_in;
    logic [XLEN-1:0] rs1_in, rs2_in;
    logic [PW-1:0]   mcand_in, carry_in;

    always_comb begin
        op_in    = op_e'(in_op);
        word_in  = (XLEN == 64) && in_word;
        rs1_in   = word_in ? (in_rs1 & WORD_MASK) : in_rs1;
        rs2_in   = word_in ? (in_rs2 & WORD_MASK) : in_rs2;
        zero_in  = (rs1_in == '0) || (rs2_in == '0);
        mcand_in = (!word_in && rs1_signed(op_in)) ? {{XLEN{rs1_in[XLEN-1]}}, rs1_in}
                                                   : {{XLEN{1'b0}}, rs1_in};
        // The +1 of the negated MSB partial product is pre-seeded into the carry vector.
        carry_in = (!word_in && rs2_signed(op_in) && rs2_in[XLEN-1]) ? MSB_INJECT : '0;
    end

    logic [PW-1:0] mc1, pp0, pp1, s1, c1, c1_sh, s2, c2, full;
    logic [XLEN-1:0] res;

    always_comb begin
        mc1 = mcand_q << 1;
        pp0 = mplier_q[0] ? mcand_q : '0;
        if (!mplier_q[1])
            pp1 = '0;
        else if ((cnt_q == '0) && sgn2_q)
            pp1 = ~mc1 & HIGH_MASK;
        else
            pp1 = mc1;
    end

    assign c1_sh = c1 << 1;

    pseudoadder #(.WIDTH(PW)) u_csa0 (
        .a(sum_q), .b(carry_q), .c(pp0), .sum(s1), .carry(c1)
    );

    pseudoadder #(.WIDTH(PW)) u_csa1 (
        .a(s1), .b(c1_sh), .c(pp1), .sum(s2), .carry(c2)
    );

    assign full = sum_q + carry_q;

    always_comb begin
        if (word_q)
            res = XLEN'($signed(full[31:0]));
        else if (op_q == OP_MUL)
            res = full[XLEN-1:0];
        else
            res = full[PW-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            op_q       <= OP_MUL;
            word_q     <= 1'b0;
            sgn2_q     <= 1'b0;
            cnt_q      <= '0;
            sum_q      <= '0;
            carry_q    <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q     <= op_in;
                        word_q   <= word_in;
                        sgn2_q   <= !word_in && rs2_signed(op_in);
                        in_ready <= 1'b0;
                        if (zero_in) begin
                            state      <= ST_DONE;
                            out_valid  <= 1'b1;
                            out_result <= '0;
                        end else begin
                            state    <= ST_CALC;
                            cnt_q    <= CNT_LOAD;
                            sum_q    <= '0;
                            carry_q  <= carry_in;
                            mcand_q  <= mcand_in;
                            mplier_q <= rs2_in;
                        end
                    end
                end
                ST_CALC: begin
                    sum_q    <= s2;
                    carry_q  <= c2 << 1;
                    mcand_q  <= mcand_q << 2;
                    mplier_q <= mplier_q >> 2;
                    if (cnt_q == '0)
                        state <= ST_FINAL;
                    else
                        cnt_q <= cnt_q - 1'b1;
                end
                ST_FINAL: begin
                    out_result <= res;
                    out_valid  <= 1'b1;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: transaction-level timing/result model checked every cycle,
// directed vectors with literal expectations, then a randomized traffic phase.
module tb_mul_sequencer;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      in_op = 2'b00;
    logic            in_word = 1'b0;
    logic [XLEN-1:0] in_rs1 = '0;
    logic [XLEN-1:0] in_rs2 = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mul_sequencer #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_word(in_word), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference product from plain 128-bit arithmetic.
    function automatic logic [63:0] golden(input logic [1:0] op, input logic word,
                                           input logic [63:0] a, input logic [63:0] b);
        logic [127:0] pa, pb, p;
        logic [63:0]  w;
        if (word) begin
            w = {32'b0, a[31:0]} * {32'b0, b[31:0]};
            return {{32{w[31]}}, w[31:0]};
        end
        pa = (op == 2'b01 || op == 2'b10) ? {{64{a[63]}}, a} : {64'b0, a};
        pb = (op == 2'b01) ? {{64{b[63]}}, b} : {64'b0, b};
        p  = pa * pb;
        return (op == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    function automatic bit is_zero(input logic word, input logic [63:0] a, input logic [63:0] b);
        if (word) return (a[31:0] == 32'h0) || (b[31:0] == 32'h0);
        return (a == 64'h0) || (b == 64'h0);
    endfunction

    // Model: one outstanding op; result visible a fixed number of cycles after acceptance.
    bit          busy = 1'b0;
    logic [63:0] m_exp = '0;
    int          n = 0;
    int          ready_n = 0;

    always @(negedge clk) begin
        n++;
        if (!rst_n) begin
            check("reset out_valid", 64'(out_valid), 64'd0);
            busy = 1'b0;
        end else begin
            check("model in_ready", 64'(in_ready), 64'(!busy));
            check("model out_valid", 64'(out_valid), 64'(busy && n >= ready_n));
            if (busy && n >= ready_n)
                check("model out_result", out_result, m_exp);
            if (flush)
                busy = 1'b0;
            else if (!busy && in_valid) begin
                busy    = 1'b1;
                m_exp   = golden(in_op, in_word, in_rs1, in_rs2);
                ready_n = n + 1 + (is_zero(in_word, in_rs1, in_rs2) ? 0 : XLEN / 2 + 1);
            end else if (busy && n >= ready_n && out_ready)
                busy = 1'b0;
        end
    end

    task automatic run_op(input string name, input logic [1:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                          input int exp_lat, input int hold, input bit leave);
        bit got;
        int k;
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = op; in_word = word; in_rs1 = a; in_rs2 = b; out_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
        end
        if (!got) begin
            check({name, " accept timeout"}, 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (out_valid) begin k = i; break; end
        end
        check({name, " latency"}, 64'(k), 64'(exp_lat));
        check({name, " result"}, out_result, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, " hold valid"}, 64'(out_valid), 64'd1);
            check({name, " hold result"}, out_result, exp);
            check({name, " hold in_ready"}, 64'(in_ready), 64'd0);
        end
        if (!leave) begin
            @(posedge clk); #1; out_ready = 1'b1;
            @(posedge clk); #1; out_ready = 1'b0;
        end
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(0, 15));
            4:       return {32'($urandom), 32'h0};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_result", out_result, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset in_ready", 64'(in_ready), 64'd1);

        run_op("mul 7x6",      2'b00, 1'b0, 64'd7, 64'd6, 64'd42, 34, 0, 1'b0);
        run_op("mulh min^2",   2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'h4000_0000_0000_0000, 34, 0, 1'b0);
        run_op("mulhu ones^2", 2'b11, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0, 1'b0);
        run_op("mulhsu -1x2",  2'b10, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0, 1'b0);
        run_op("mulw wrap",    2'b00, 1'b1, 64'h0000_0001_8000_0000, 64'd2, 64'h0, 34, 0, 1'b0);
        run_op("mulw sext",    2'b00, 1'b1, 64'h0000_0000_4000_0000, 64'd2,
               64'hFFFF_FFFF_8000_0000, 34, 0, 1'b0);
        run_op("mul -3x5",     2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
               64'hFFFF_FFFF_FFFF_FFF1, 34, 0, 1'b0);
        run_op("mulh -3x5",    2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
               64'hFFFF_FFFF_FFFF_FFFF, 34, 0, 1'b0);
        run_op("zero rs2",     2'b01, 1'b0, 64'd123, 64'd0, 64'd0, 1, 10, 1'b0);
        run_op("mulw masked0", 2'b00, 1'b1, 64'h0000_0001_0000_0000, 64'd9, 64'd0, 1, 0, 1'b0);

        // Flush during CALC, then a clean op at nominal latency.
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = 2'b00; in_word = 1'b0; in_rs1 = 64'd100; in_rs2 = 64'd200;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("flush no valid", 64'(out_valid), 64'd0);
        end
        run_op("mul 3x5 after flush", 2'b00, 1'b0, 64'd3, 64'd5, 64'd15, 34, 0, 1'b0);

        // Reset while DONE discards the result.
        run_op("mul held in done", 2'b00, 1'b0, 64'd11, 64'd13, 64'd143, 34, 2, 1'b1);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("reset no valid", 64'(out_valid), 64'd0);
        end
        run_op("mul 3x5 after reset", 2'b00, 1'b0, 64'd3, 64'd5, 64'd15, 34, 0, 1'b0);

        // Random traffic; the per-cycle model does all checking here.
        for (int c = 0; c < 60000; c++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            in_op     = 2'($urandom_range(0, 3));
            in_word   = ($urandom_range(0, 3) == 0);
            in_rs1    = rnd64();
            in_rs2    = rnd64();
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 63) == 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("drain idle", 64'(in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
